// File: rtl/disp_pkg.sv
// Shared types and helpers for the go/finish job dispatcher.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } disp_state_t;

  // Ceiling log2, never less than 1; sizes the WAIT timer.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/disp_fifo.sv
// Show-ahead synchronous FIFO holding queued job tags.
module disp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ID_W-1:0]          din,
  output logic [ID_W-1:0]          dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [ID_W-1:0] r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic            w_push;
  logic            w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  // Pointers carry one extra bit so full and empty differ only in the MSB.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign count = r_wr_ptr - r_rd_ptr;
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/go_dispatcher.sv
// Job queue feeding a go/finish FSM: one go pulse per job, serialised,
// with finish/timeout tracking and sticky error flags.
module go_dispatcher
  import disp_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic [ID_W-1:0]        req_id,
  output logic                   req_ready,
  output logic                   go,
  output logic [ID_W-1:0]        go_id,
  input  logic                   finish,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pending,
  output logic [CNT_W-1:0]       done_cnt,
  output logic [ID_W-1:0]        last_done_id,
  output logic                   timeout_err,
  output logic                   ovf_err,
  input  logic                   err_clr,
  output logic [1:0]             disp_state
);

  localparam int unsigned TW = clog2(TIMEOUT);

  disp_state_t       r_state;
  logic [TW-1:0]     r_timer;
  logic              r_go;
  logic [ID_W-1:0]   r_go_id;
  logic [CNT_W-1:0]  r_done_cnt;
  logic [ID_W-1:0]   r_last_done_id;
  logic              r_timeout_err;
  logic              r_ovf_err;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic [ID_W-1:0]   w_head;
  logic [$clog2(DEPTH):0] w_count;

  assign w_pop = (r_state == IDLE) && !w_empty;

  disp_fifo #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req),
    .pop   (w_pop),
    .din   (req_id),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Dispatch FSM; an error set later in this block overrides an err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_timer        <= '0;
      r_go           <= 1'b0;
      r_go_id        <= '0;
      r_done_cnt     <= '0;
      r_last_done_id <= '0;
      r_timeout_err  <= 1'b0;
      r_ovf_err      <= 1'b0;
    end else begin
      r_go <= 1'b0;
      if (err_clr) begin
        r_timeout_err <= 1'b0;
        r_ovf_err     <= 1'b0;
      end
      if (req && w_full) r_ovf_err <= 1'b1;

      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_go_id <= w_head;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_go    <= 1'b1;
          r_timer <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (finish) begin
            r_done_cnt     <= r_done_cnt + CNT_W'(1);
            r_last_done_id <= r_go_id;
            r_state        <= GAP;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_timeout_err <= 1'b1;
            r_state       <= GAP;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        GAP: begin
          // Hold here until a level finish drops so it cannot complete the next job.
          if (!finish) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready    = !w_full;
  assign go           = r_go;
  assign go_id        = r_go_id;
  assign busy         = (r_state != IDLE);
  assign pending      = w_count;
  assign done_cnt     = r_done_cnt;
  assign last_done_id = r_last_done_id;
  assign timeout_err  = r_timeout_err;
  assign ovf_err      = r_ovf_err;
  assign disp_state   = r_state;

endmodule
